// File: rtl/seq_pkg.sv
// Shared definitions for the issue sequencer: state encodings and default constants.
package seq_pkg;

  // Long-instruction opcode used when the top is not overridden.
  localparam int unsigned LongOpcodeDflt = 12;

  // Sequencer state encodings; also exported on seq_state for debug.
  typedef enum logic [2:0] {
    StReset   = 3'd0,
    StFetch   = 3'd1,
    StFetchImm = 3'd2,
    StIntSave = 3'd3,
    StIntVec  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/seq_intr_latch.sv
// Interrupt edge detector and pending flag. A new rising edge wins over a clear in the
// same cycle so an interrupt arriving during vector load is not lost.
module seq_intr_latch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic intr_i,
  input  logic clear_i,
  output logic pending_o
);

  logic intr_q;
  logic pending_q;
  logic rise;

  assign rise      = intr_i & ~intr_q;
  assign pending_o = pending_q;

  // Sample intr and update pending (synchronous reset).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      intr_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      intr_q <= intr_i;
      if (rise) begin
        pending_q <= 1'b1;
      end else if (clear_i) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/issue_sequencer.sv
// Pipeline issue sequencer: drives PC / IF-ID enables, bubble injection and interrupt
// entry. Interrupt support (INT_SAVE, INT_VEC, pending latch) is compiled in only when
// the SEQ_INTR_EN macro is defined; otherwise intr is ignored.
module issue_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned OPCODE_W       = 4,
  parameter int unsigned LONG_OPCODE    = LongOpcodeDflt,
  parameter int unsigned IMM_WORDS      = 1,
  parameter int unsigned INT_SAVE_WORDS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                intr,
  input  logic                load_use_hazard,
  input  logic                branch_taken,
  output logic                pc_write_en,
  output logic                if_id_write_en,
  output logic                inject_bubble,
  output logic                inject_int,
  output logic                int_ack,
  output logic [2:0]          seq_state
);

  seq_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       is_long;
  logic       pend_clr;

  assign is_long = (opcode == OPCODE_W'(LONG_OPCODE));

`ifdef SEQ_INTR_EN
  logic pending;

  seq_intr_latch u_intr_latch (
    .clk_i     (clk),
    .rst_ni    (rst),
    .intr_i    (intr),
    .clear_i   (pend_clr),
    .pending_o (pending)
  );
`else
  logic unused_intr;
  assign unused_intr = intr ^ pend_clr;
`endif

  // State and counter registers (synchronous active-low reset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StReset;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; reset forces the RESET-state outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    inject_bubble  = 1'b0;
    inject_int     = 1'b0;
    int_ack        = 1'b0;
    pend_clr       = 1'b0;
    unique case (state_q)
      StReset: begin
        inject_bubble = 1'b1;
        state_d       = StFetch;
      end
      StFetch: begin
        if (branch_taken) begin
          inject_bubble = 1'b1;
`ifdef SEQ_INTR_EN
        end else if (pending && !is_long) begin
          // Long instructions are never split; the interrupt waits for the next FETCH.
          inject_int     = 1'b1;
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          cnt_d          = 3'(INT_SAVE_WORDS - 1);
          state_d        = StIntSave;
`endif
        end else if (load_use_hazard) begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          inject_bubble  = 1'b1;
        end else if (is_long) begin
          if_id_write_en = 1'b0;
          inject_bubble  = 1'b1;
          cnt_d          = 3'(IMM_WORDS - 1);
          state_d        = StFetchImm;
        end
      end
      StFetchImm: begin
        if (branch_taken) begin
          inject_bubble = 1'b1;
          cnt_d         = 3'd0;
          state_d       = StFetch;
        end else if (cnt_q != 3'd0) begin
          if_id_write_en = 1'b0;
          inject_bubble  = 1'b1;
          cnt_d          = cnt_q - 3'd1;
        end else begin
          state_d = StFetch;
        end
      end
`ifdef SEQ_INTR_EN
      StIntSave: begin
        inject_int     = 1'b1;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = StIntVec;
        end
      end
      StIntVec: begin
        inject_bubble = 1'b1;
        int_ack       = 1'b1;
        pend_clr      = 1'b1;
        state_d       = StFetch;
      end
`endif
      default: begin
        state_d = StReset;
      end
    endcase

    if (!rst) begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      inject_bubble  = 1'b1;
      inject_int     = 1'b0;
      int_ack        = 1'b0;
    end
  end

  assign seq_state = rst ? state_q : StReset;

endmodule

// File: tb/tb_issue_sequencer.sv
// Directed bench for issue_sequencer (IMM_WORDS=3, INT_SAVE_WORDS=2, long opcode 12).
// Expected word per cycle: {pc_write_en, if_id_write_en, inject_bubble, inject_int,
// int_ack, seq_state[2:0]}, sampled mid-cycle before the next rising edge.
module tb_issue_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       intr;
  logic       load_use_hazard;
  logic       branch_taken;
  logic       pc_write_en;
  logic       if_id_write_en;
  logic       inject_bubble;
  logic       inject_int;
  logic       int_ack;
  logic [2:0] seq_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  issue_sequencer #(
    .OPCODE_W       (4),
    .LONG_OPCODE    (12),
    .IMM_WORDS      (3),
    .INT_SAVE_WORDS (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .opcode          (opcode),
    .intr            (intr),
    .load_use_hazard (load_use_hazard),
    .branch_taken    (branch_taken),
    .pc_write_en     (pc_write_en),
    .if_id_write_en  (if_id_write_en),
    .inject_bubble   (inject_bubble),
    .inject_int      (inject_int),
    .int_ack         (int_ack),
    .seq_state       (seq_state)
  );

  typedef struct packed {
    logic       r;
    logic [3:0] op;
    logic       ir;
    logic       lu;
    logic       br;
    logic [7:0] exp;
  } vec_t;

  // Apply one cycle of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic step(input string name, input logic r, input logic [3:0] op,
                      input logic ir, input logic lu, input logic br,
                      input logic [7:0] exp);
    logic [7:0] act;
    rst             = r;
    opcode          = op;
    intr            = ir;
    load_use_hazard = lu;
    branch_taken    = br;
    #3;
    act = {pc_write_en, if_id_write_en, inject_bubble, inject_int, int_ack, seq_state};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[28];

  initial begin
    // Reset, flush/hazard priority, long fetch, branch abort, reset mid long fetch.
    vecs[0]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1110_0000};
    vecs[1]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1110_0000};
    vecs[2]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1110_0000};
    vecs[3]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0001};
    vecs[4]  = '{1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 8'b1110_0001};
    vecs[5]  = '{1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 8'b0010_0001};
    vecs[6]  = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 8'b1010_0001};
    vecs[7]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 8'b1010_0010};
    vecs[8]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 8'b1010_0010};
    vecs[9]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 8'b1100_0010};
    vecs[10] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0001};
    vecs[11] = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 8'b1010_0001};
    vecs[12] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 8'b1110_0010};
    vecs[13] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0001};
    vecs[14] = '{1'b1, 4'd12, 1'b0, 1'b1, 1'b0, 8'b0010_0001};
    vecs[15] = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 8'b1010_0001};
    vecs[16] = '{1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 8'b1010_0010};
    vecs[17] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1010_0010};
    vecs[18] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0010};
    vecs[19] = '{1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 8'b1100_0001};
    vecs[20] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0001};
    vecs[21] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1110_0000};
    vecs[22] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1110_0000};
    vecs[23] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0001};
    vecs[24] = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 8'b1010_0001};
    vecs[25] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1110_0000};
    vecs[26] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1110_0000};
    vecs[27] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0001};

    for (int k = 0; k < 28; k++) begin
      step($sformatf("vec%0d", k), vecs[k].r, vecs[k].op, vecs[k].ir, vecs[k].lu,
           vecs[k].br, vecs[k].exp);
    end

`ifdef SEQ_INTR_EN
    // Edge during long fetch: deferred to next FETCH, 2 save cycles, 1 vector cycle.
    step("defer_long",  1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 8'b1010_0001);
    step("defer_imm2",  1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b1010_0010);
    step("defer_imm1",  1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b1010_0010);
    step("defer_imm0",  1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b1100_0010);
    step("int_entry",   1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b0001_0001);
    step("int_save1",   1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 8'b0001_0011);
    step("int_save0",   1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b0001_0011);
    step("int_vec",     1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b1110_1100);
    step("post_vec",    1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b1100_0001);
    // Branch beats a pending interrupt, which beats a load-use stall.
    step("low_intr",    1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0001);
    step("rise_intr",   1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b1100_0001);
    step("br_over_int", 1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 8'b1110_0001);
    step("int_over_lu", 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 8'b0001_0001);
    step("save1_b",     1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b0001_0011);
    step("save0_b",     1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b0001_0011);
    // New edge during INT_VEC keeps pending set; taken on the next FETCH.
    step("vec_rise",    1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b1110_1100);
    step("retake",      1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b0001_0001);
    step("save1_c",     1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b0001_0011);
    // Reset mid-save: back to RESET, pending dropped, no ack afterwards.
    step("rst_in_save", 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1110_0000);
    step("rst_reset",   1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1110_0000);
    step("rst_fetch1",  1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0001);
    step("rst_fetch2",  1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0001);
`else
    // Interrupts compiled out: intr toggling must not disturb FETCH.
    for (int k = 0; k < 10; k++) begin
      step($sformatf("no_intr%0d", k), 1'b1, 4'd0, k[0], 1'b0, 1'b0, 8'b1100_0001);
    end
    step("no_intr_long", 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 8'b1010_0001);
    step("no_intr_imm2", 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1010_0010);
    step("no_intr_imm1", 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b1010_0010);
    step("no_intr_imm0", 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'b1100_0010);
    step("no_intr_back", 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'b1100_0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_sequencer.md
ISSUE_SEQUENCER -- requirements
Module: issue_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 4, opcode field width.
REQ-002 Parameter LONG_OPCODE, default 12, opcode value of multi-word instructions.
REQ-003 Parameter IMM_WORDS, default 1, range 1..7; extra fetch words per long instruction.
REQ-004 Parameter INT_SAVE_WORDS, default 2, range 1..7; stack-save cycles per interrupt entry.
REQ-005 Port clk  in  1  single clock, rising edge.
REQ-006 Port rst  in  1  reset; synchronous and active-low.
REQ-007 Port opcode  in  OPCODE_W  opcode of the instruction in IF/ID.
REQ-008 Port intr  in  1  external interrupt request, level, sampled each cycle.
REQ-009 Port load_use_hazard  in  1  decode-stage hazard, requests a one-cycle stall.
REQ-010 Port branch_taken  in  1  execute-stage redirect, requests a flush.
REQ-011 Port pc_write_en  out  1  PC register enable.
REQ-012 Port if_id_write_en  out  1  IF/ID register enable.
REQ-013 Port inject_bubble  out  1  forces NOP control into ID/EX.
REQ-014 Port inject_int  out  1  selects interrupt-save control and PC mux path.
REQ-015 Port int_ack  out  1  one-cycle pulse on interrupt vector load.
REQ-016 Port seq_state  out  3  current state encoding, for debug.

Function
REQ-017 States: RESET, FETCH, FETCH_IMM, INT_SAVE, INT_VEC; registered, with 3-bit down counter cnt.
REQ-018 Default outputs: pc_write_en=1, if_id_write_en=1, inject_bubble=0, inject_int=0, int_ack=0.
REQ-019 RESET: inject_bubble=1; next state FETCH.
REQ-020 FETCH priority, highest first: branch_taken, pending interrupt, load_use_hazard, long opcode, normal.
REQ-021 FETCH with branch_taken: inject_bubble=1; remain FETCH.
REQ-022 FETCH with pending interrupt and opcode!=LONG_OPCODE: inject_int=1, pc_write_en=0, if_id_write_en=0; cnt=INT_SAVE_WORDS-1; next INT_SAVE.
REQ-023 FETCH with load_use_hazard: pc_write_en=0, if_id_write_en=0, inject_bubble=1; remain FETCH.
REQ-024 FETCH with opcode==LONG_OPCODE: if_id_write_en=0, inject_bubble=1; cnt=IMM_WORDS-1; next FETCH_IMM.
REQ-025 FETCH_IMM with cnt>0: if_id_write_en=0, inject_bubble=1; cnt decrements.
REQ-026 FETCH_IMM with cnt==0: default outputs; next FETCH. Total long-instruction fetch is 1+IMM_WORDS cycles.
REQ-027 branch_taken in FETCH_IMM: inject_bubble=1, cnt cleared, next FETCH (immediate fetch aborted).
REQ-028 INT_SAVE: inject_int=1, pc_write_en=0, if_id_write_en=0. While cnt>0, cnt decrements; at cnt==0, next INT_VEC. Lasts INT_SAVE_WORDS cycles; branch_taken and load_use_hazard are ignored.
REQ-029 INT_VEC: pc_write_en=1, inject_bubble=1, int_ack=1; pending cleared; next FETCH.
REQ-030 pending sets on intr rising edge (intr=1, previous sample 0) and stays set until INT_VEC.
REQ-031 A rising edge in the INT_VEC cycle leaves pending=1, so the next interrupt is taken on the following eligible FETCH cycle.
REQ-032 A pending interrupt never splits a long instruction; it is taken at the next FETCH boundary.

Reset
REQ-033 rst=0 at a clock edge, in any state, forces state RESET, cnt=0, pending=0, intr sample=0.
REQ-034 While rst=0, outputs equal the RESET values: pc_write_en=1, if_id_write_en=1, inject_bubble=1, inject_int=0, int_ack=0, seq_state=RESET encoding.

Configuration
REQ-035 Macro SEQ_INTR_EN, when defined, compiles in the interrupt logic: INT_SAVE, INT_VEC, pending.
REQ-036 Without SEQ_INTR_EN: intr is ignored; inject_int and int_ack are tied 0; FETCH priority is branch_taken, load_use_hazard, long opcode.

Structure
REQ-037 Shared package seq_pkg holds state encodings (RESET=0, FETCH=1, FETCH_IMM=2, INT_SAVE=3, INT_VEC=4) and the LONG_OPCODE default constant.
REQ-038 Sub-module seq_intr_latch holds the edge detect and pending flag, with a clear input and set-wins-over-clear priority.

Verification
REQ-039 Reset release, opcode=0 -> RESET cycle (inject_bubble=1), then FETCH with default outputs.
REQ-040 IMM_WORDS=3, opcode=12 in FETCH -> 3 cycles if_id_write_en=0 with bubble, 1 normal cycle, back to FETCH.
REQ-041 intr edge during a long-instruction fetch -> interrupt deferred to the next FETCH; INT_SAVE lasts 2 cycles, then INT_VEC with int_ack=1 for 1 cycle.
REQ-042 branch_taken and load_use_hazard asserted together in FETCH -> bubble with pc_write_en=1 (flush wins).
REQ-043 rst=0 mid-INT_SAVE -> next cycle in RESET with pending=0; no int_ack is produced.
REQ-044 Build without SEQ_INTR_EN, toggle intr -> inject_int and int_ack stay 0; seq_state never reaches 3 or 4.
